cs161_mc_control: RTL and testbench

CS161_MC_CONTROL -- requirements
Module: cs161_mc_control

---
 rtl/cs161_mc_pkg.sv | 41 ++++
 rtl/cs161_alu_ctrl.sv | 25 ++
 rtl/cs161_mc_control.sv | 186 ++++++++++++++++++
 tb/tb_cs161_mc_control.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cs161_mc_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcodes,
// funct fields and ALU operation codes.
package cs161_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/cs161_alu_ctrl.sv
// R-type funct decode to ALU operation; unknown functs fall back to ADD
// with valid low so the FSM can flag them.
module cs161_alu_ctrl
    import cs161_mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       valid
);

    always_comb begin
        alu_op = ALU_ADD;
        valid  = 1'b1;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_NOR:  alu_op = ALU_NOR;
            FN_SLT:  alu_op = ALU_SLT;
            default: valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/cs161_mc_control.sv
// Multicycle MIPS-subset control FSM with retired-instruction counter.
// state | meaning
// FETCH  0 | read instruction, PC+4    DECODE 1 | register read, branch target
// MEMADR 2 | lw/sw address             MEMRD  3 | load access (waits mem_ready)
// MEMWB  4 | load writeback            MEMWR  5 | store access (waits mem_ready)
// EXEC   6 | R-type ALU op             ALUWB  7 | R-type writeback
// BRANCH 8 | beq compare / PC update   ADDIEX 9 | addi ALU op
// ADDIWB 10| addi writeback            JUMP   11| PC <- jump target
module cs161_mc_control
    import cs161_mc_pkg::*;
#(
    parameter int CNT_WIDTH = 32,
    parameter bit FIXED_MEM = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           instr_op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_en,
    output logic                 iord,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 reg_write,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           pc_src,
    output logic [3:0]           alu_op,
    output logic [3:0]           state,
    output logic [CNT_WIDTH-1:0] instr_count,
    output logic                 illegal
);

    state_t     cur;
    logic       mem_rdy;
    logic [3:0] fn_op;
    logic       fn_valid;
    logic       illegal_q;
    logic       retire;

    assign mem_rdy = FIXED_MEM ? 1'b1 : mem_ready;
    assign state   = cur;
    assign illegal = illegal_q & ~rst;

    cs161_alu_ctrl u_alu_ctrl (
        .funct  (funct),
        .alu_op (fn_op),
        .valid  (fn_valid)
    );

    // An instruction retires on the cycle it leaves its final state.
    always_comb begin
        retire = 1'b0;
        case (cur)
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: retire = 1'b1;
            S_MEMWR: retire = mem_rdy;
            default: retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur         <= S_FETCH;
            instr_count <= '0;
            illegal_q   <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            if (retire)
                instr_count <= instr_count + CNT_WIDTH'(1);
            case (cur)
                S_FETCH:  if (mem_rdy) cur <= S_DECODE;
                S_DECODE: begin
                    case (instr_op)
                        OP_RTYPE:     cur <= S_EXEC;
                        OP_LW, OP_SW: cur <= S_MEMADR;
                        OP_BEQ:       cur <= S_BRANCH;
                        OP_ADDI:      cur <= S_ADDIEX;
                        OP_J:         cur <= S_JUMP;
                        default: begin
                            cur       <= S_FETCH;
                            illegal_q <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR: cur <= (instr_op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (mem_rdy) cur <= S_MEMWB;
                S_MEMWR:  if (mem_rdy) cur <= S_FETCH;
                S_EXEC: begin
                    if (fn_valid) begin
                        cur <= S_ALUWB;
                    end else begin
                        cur       <= S_FETCH;
                        illegal_q <= 1'b1;
                    end
                end
                S_ADDIEX: cur <= S_ADDIWB;
                default:  cur <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_op     = ALU_AND;
        case (cur)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = ALU_ADD;
                ir_write  = mem_rdy;
                pc_en     = mem_rdy;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = fn_op;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = 2'b01;
                pc_en     = zero;
            end
            S_JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
            end
            default: ;
        endcase
        // Reset overrides every datapath control so nothing is written mid-abort.
        if (rst) begin
            pc_en      = 1'b0;
            iord       = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            pc_src     = 2'b00;
            alu_op     = 4'b0000;
        end
    end

endmodule

// File: tb/tb_cs161_mc_control.sv
// Scoreboard bench for cs161_mc_control: stimulus pushes hand-derived expected
// outputs per cycle, a negedge monitor pops and compares.
module tb_cs161_mc_control;

    localparam int CW = 4;

    // ctrl packing: {pc_en,iord,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,alu_src_a,alu_src_b[1:0],pc_src[1:0]}
    localparam logic [12:0] C_ZERO    = 13'b0_0_0_0_0_0_0_0_0_00_00;
    localparam logic [12:0] C_FETCH   = 13'b1_0_1_0_1_0_0_0_0_01_00;
    localparam logic [12:0] C_FETCH_W = 13'b0_0_1_0_0_0_0_0_0_01_00;
    localparam logic [12:0] C_DECODE  = 13'b0_0_0_0_0_0_0_0_0_11_00;
    localparam logic [12:0] C_ADDR    = 13'b0_0_0_0_0_0_0_0_1_10_00;
    localparam logic [12:0] C_MEMRD   = 13'b0_1_1_0_0_0_0_0_0_00_00;
    localparam logic [12:0] C_MEMWR   = 13'b0_1_0_1_0_0_0_0_0_00_00;
    localparam logic [12:0] C_MEMWB   = 13'b0_0_0_0_0_0_1_1_0_00_00;
    localparam logic [12:0] C_EXEC    = 13'b0_0_0_0_0_0_0_0_1_00_00;
    localparam logic [12:0] C_ALUWB   = 13'b0_0_0_0_0_1_0_1_0_00_00;
    localparam logic [12:0] C_ADDIWB  = 13'b0_0_0_0_0_0_0_1_0_00_00;
    localparam logic [12:0] C_BR_T    = 13'b1_0_0_0_0_0_0_0_1_00_01;
    localparam logic [12:0] C_BR_N    = 13'b0_0_0_0_0_0_0_0_1_00_01;
    localparam logic [12:0] C_JUMP    = 13'b1_0_0_0_0_0_0_0_0_00_10;

    localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010;
    localparam logic [3:0] A_SUB = 4'b0110, A_SLT = 4'b0111, A_NOR = 4'b1100;

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;

    logic clk = 1'b0;
    logic rst, zero, mem_ready;
    logic [5:0] instr_op, funct;
    logic pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [3:0] alu_op, state;
    logic [CW-1:0] instr_count;
    logic illegal;

    cs161_mc_control #(.CNT_WIDTH(CW), .FIXED_MEM(1'b0)) dut (
        .clk(clk), .rst(rst), .instr_op(instr_op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_op(alu_op), .state(state),
        .instr_count(instr_count), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         nm;
        logic [3:0]    st;
        logic [12:0]   ctrl;
        logic [3:0]    aop;
        logic [CW-1:0] cnt;
        logic          ill;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int n_vec = 0;
    int n_bad = 0;
    logic [CW-1:0] ec = '0;
    logic eill = 1'b0;
    logic [12:0] act_ctrl;

    assign act_ctrl = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                       reg_write, alu_src_a, alu_src_b, pc_src};

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_vec++;
            if (state !== mon_e.st || act_ctrl !== mon_e.ctrl || alu_op !== mon_e.aop ||
                instr_count !== mon_e.cnt || illegal !== mon_e.ill) begin
                n_bad++;
                $display("FAIL %s: got st=%0d ctrl=%b aop=%b cnt=%0d ill=%b, expected st=%0d ctrl=%b aop=%b cnt=%0d ill=%b",
                         mon_e.nm, state, act_ctrl, alu_op, instr_count, illegal,
                         mon_e.st, mon_e.ctrl, mon_e.aop, mon_e.cnt, mon_e.ill);
            end
        end
    end

    task automatic cyc(input string nm, input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic mr, input logic [3:0] st,
                       input logic [12:0] ctrl, input logic [3:0] aop);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; instr_op = op; funct = fn; zero = z; mem_ready = mr;
        e.nm = nm; e.st = st; e.ctrl = ctrl; e.aop = aop; e.cnt = ec; e.ill = eill;
        sb.push_back(e);
        eill = 1'b0;
    endtask

    task automatic fetch_dec(input logic [5:0] op, input logic [5:0] fn, input logic z);
        cyc("fetch", 1'b0, op, fn, z, 1'b1, 4'd0, C_FETCH, A_ADD);
        cyc("decode", 1'b0, op, fn, z, 1'b1, 4'd1, C_DECODE, A_ADD);
    endtask

    task automatic do_rtype(input logic [5:0] fn, input logic [3:0] aop);
        fetch_dec(R, fn, 1'b0);
        cyc("exec", 1'b0, R, fn, 1'b0, 1'b1, 4'd6, C_EXEC, aop);
        cyc("aluwb", 1'b0, R, fn, 1'b0, 1'b1, 4'd7, C_ALUWB, A_AND);
        ec++;
    endtask

    task automatic do_j();
        fetch_dec(J, 6'd0, 1'b0);
        cyc("jump", 1'b0, J, 6'd0, 1'b0, 1'b1, 4'd11, C_JUMP, A_AND);
        ec++;
    endtask

    initial begin
        rst = 1'b1; instr_op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        cyc("reset", 1'b1, R, 6'd0, 1'b0, 1'b1, 4'd0, C_ZERO, 4'b0000);

        do_rtype(6'b100000, A_ADD);
        do_rtype(6'b100010, A_SUB);
        do_rtype(6'b100100, A_AND);
        do_rtype(6'b100101, A_OR);
        do_rtype(6'b100111, A_NOR);
        do_rtype(6'b101010, A_SLT);

        fetch_dec(R, 6'b111111, 1'b0);
        cyc("exec_badfn", 1'b0, R, 6'b111111, 1'b0, 1'b1, 4'd6, C_EXEC, A_ADD);
        eill = 1'b1;

        fetch_dec(LW, 6'd0, 1'b0);
        cyc("memadr", 1'b0, LW, 6'd0, 1'b0, 1'b1, 4'd2, C_ADDR, A_ADD);
        for (int i = 0; i < 3; i++)
            cyc("memrd_wait", 1'b0, LW, 6'd0, 1'b0, 1'b0, 4'd3, C_MEMRD, A_AND);
        cyc("memrd", 1'b0, LW, 6'd0, 1'b0, 1'b1, 4'd3, C_MEMRD, A_AND);
        cyc("memwb", 1'b0, LW, 6'd0, 1'b0, 1'b1, 4'd4, C_MEMWB, A_AND);
        ec++;

        fetch_dec(SW, 6'd0, 1'b0);
        cyc("memadr_sw", 1'b0, SW, 6'd0, 1'b0, 1'b1, 4'd2, C_ADDR, A_ADD);
        cyc("memwr", 1'b0, SW, 6'd0, 1'b0, 1'b1, 4'd5, C_MEMWR, A_AND);
        ec++;

        fetch_dec(BEQ, 6'd0, 1'b1);
        cyc("branch_taken", 1'b0, BEQ, 6'd0, 1'b1, 1'b1, 4'd8, C_BR_T, A_SUB);
        ec++;
        fetch_dec(BEQ, 6'd0, 1'b0);
        cyc("branch_not", 1'b0, BEQ, 6'd0, 1'b0, 1'b1, 4'd8, C_BR_N, A_SUB);
        ec++;

        fetch_dec(ADDI, 6'd0, 1'b0);
        cyc("addiex", 1'b0, ADDI, 6'd0, 1'b0, 1'b1, 4'd9, C_ADDR, A_ADD);
        cyc("addiwb", 1'b0, ADDI, 6'd0, 1'b0, 1'b1, 4'd10, C_ADDIWB, A_AND);
        ec++;

        fetch_dec(6'b111111, 6'd0, 1'b0);
        eill = 1'b1;

        for (int i = 0; i < 5; i++)
            do_j();

        // 16 retirements so far: a 4-bit count is back at zero here.
        fetch_dec(SW, 6'd0, 1'b0);
        cyc("memadr_abort", 1'b0, SW, 6'd0, 1'b0, 1'b1, 4'd2, C_ADDR, A_ADD);
        cyc("memwr_wait", 1'b0, SW, 6'd0, 1'b0, 1'b0, 4'd5, C_MEMWR, A_AND);
        cyc("memwr_rst", 1'b1, SW, 6'd0, 1'b0, 1'b1, 4'd5, C_ZERO, 4'b0000);
        ec = '0;
        cyc("post_rst", 1'b0, SW, 6'd0, 1'b0, 1'b0, 4'd0, C_FETCH_W, A_ADD);
        cyc("post_rst_go", 1'b0, J, 6'd0, 1'b0, 1'b1, 4'd0, C_FETCH, A_ADD);
        cyc("decode_j", 1'b0, J, 6'd0, 1'b0, 1'b1, 4'd1, C_DECODE, A_ADD);
        cyc("jump_last", 1'b0, J, 6'd0, 1'b0, 1'b1, 4'd11, C_JUMP, A_AND);
        ec++;
        cyc("tail", 1'b0, R, 6'd0, 1'b0, 1'b0, 4'd0, C_FETCH_W, A_ADD);

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
